// File: rtl/mem_stream_unit.sv
// mem_stream_unit: DEPTH x DATA_WIDTH synchronous-read scratchpad; build-time MODE selects RAM, FIFO or strided STREAM.
// Latency: one cycle from read_en to read_data/read_valid in every mode; writes visible to reads on the next cycle.
// Backpressure: none; FIFO rejects push when full (no pop) or pop when empty and raises sticky err.
// Ports: clk, reset (synchronous, active-high); addr0, write_data, write_en, read_en in;
//        read_data, read_valid, full, empty, count (FIFO occupancy / STREAM pointer), err out.
module mem_stream_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int MODE       = 0,
    parameter int STRIDE     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   write_en,
    input  logic                   read_en,
    output logic [DATA_WIDTH-1:0]  read_data,
    output logic                   read_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   STEP      = AW'(STRIDE);
    localparam bit              IS_FIFO   = (MODE == 1);
    localparam bit              IS_STREAM = (MODE == 2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Word address: low AW bits of addr0, zero-extended when the data word is narrower than the address.
    logic [AW-1:0] addr_w;
    generate
        if (DATA_WIDTH >= AW) begin : g_addr_trunc
            assign addr_w = addr0[AW-1:0];
            if (DATA_WIDTH > AW) begin : g_addr_hi
                logic unused_addr_hi;
                assign unused_addr_hi = ^addr0[DATA_WIDTH-1:AW];
            end
        end else begin : g_addr_ext
            assign addr_w = {{(AW-DATA_WIDTH){1'b0}}, addr0};
        end
    endgenerate

    logic [AW-1:0]         rptr_q, rptr_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         sptr_q, sptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_valid_q;

    logic                  pop_ok, push_ok;
    logic                  rd_fire, wr_fire;
    logic [AW-1:0]         rd_addr, wr_addr;

    always_comb begin
        // A pop frees a slot in the same cycle, so a full FIFO still takes a simultaneous push.
        pop_ok  = read_en && !empty_q;
        push_ok = write_en && (!full_q || pop_ok);

        rd_fire = IS_FIFO ? pop_ok  : read_en;
        wr_fire = IS_FIFO ? push_ok : write_en;
        rd_addr = IS_FIFO ? rptr_q : (IS_STREAM ? sptr_q : addr_w);
        wr_addr = IS_FIFO ? wptr_q : addr_w;

        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        sptr_d  = sptr_q;
        count_d = count_q;
        err_d   = err_q;

        if (IS_FIFO) begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
            else if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
            if ((write_en && !push_ok) || (read_en && !pop_ok)) err_d = 1'b1;
        end

        if (IS_STREAM && read_en) sptr_d = sptr_q + STEP;

        full_d  = IS_FIFO && (count_d == FULL_CNT);
        empty_d = IS_FIFO && (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            sptr_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= IS_FIFO;
            err_q        <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            sptr_q       <= sptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            err_q        <= err_d;
            read_valid_q <= rd_fire;
            // Non-blocking read against the separate write block gives read-first on address collisions.
            if (rd_fire) read_data_q <= mem[rd_addr];
        end
    end

    // Storage has no reset; requests coincident with reset are dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) mem[wr_addr] <= write_data;
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign err        = err_q;
    assign count      = IS_STREAM ? {1'b0, sptr_q} : count_q;

endmodule

// File: doc/mem_stream_unit.md
# mem_stream_unit

Parametrised successor to the fixed 32-bit fabric memory primitive. A single-clock, synchronous-read scratchpad with configurable data width, depth, and one of three build-time modes: addressed RAM, FIFO with occupancy flags, or strided streaming read. It sits in a fabric tile beside the ALU, register and constant units and uses the same 32-bit-style word interface, widened or narrowed by parameter.

## Interface
- DATA_WIDTH, 32, word width of write_data, read_data and addr0
- DEPTH, 256, number of words; power of two, 2..4096; AW = log2(DEPTH)
- MODE, 0, 0 = RAM, 1 = FIFO, 2 = STREAM
- STRIDE, 1, STREAM-mode pointer increment, 1..DEPTH-1
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- addr0  in  DATA_WIDTH  word address; only bits [AW-1:0] used, upper bits ignored
- write_data  in  DATA_WIDTH  write / push data
- write_en  in  1  write (RAM, STREAM) or push (FIFO)
- read_en  in  1  read (RAM), pop (FIFO), stream step (STREAM)
- read_data  out  DATA_WIDTH  registered read result
- read_valid  out  1  high for exactly one cycle when read_data is updated
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- count  out  AW+1  FIFO occupancy / STREAM pointer
- err  out  1  sticky overflow/underflow flag

## Operation
- Storage is DEPTH x DATA_WIDTH. Contents are not cleared by reset.
- Reset values: read_data=0, read_valid=0, count=0, err=0, full=0; empty=1 in FIFO mode, else 0. Internal pointers are 0.
- RAM (MODE 0):
  - write_en writes mem[addr0[AW-1:0]] = write_data.
  - read_en captures mem[addr0] into read_data. read_valid is high the next cycle.
  - Simultaneous read and write to the same address is read-first: the old data is returned.
  - full=0, empty=0, count=0, err=0 permanently.
- FIFO (MODE 1), addr0 ignored:
  - Push is accepted when write_en && (!full || pop accepted this cycle). It writes mem[wptr] and advances wptr mod DEPTH.
  - Pop is accepted when read_en && !empty. It loads read_data=mem[rptr], sets read_valid next cycle, and advances rptr mod DEPTH.
  - count += push − pop, range 0..DEPTH. full = (count==DEPTH); empty = (count==0); both are registered and consistent with count.
  - Push+pop while full: both accepted, count unchanged.
  - Push+pop while empty: push only, pop ignored (no bypass), count→1.
  - A rejected push (full with no pop) or a rejected pop (empty) sets err=1 until reset. State is otherwise unchanged.
- STREAM (MODE 2):
  - write_en writes mem[addr0] as in RAM mode, for preloading.
  - read_en loads read_data=mem[sptr], sets read_valid next cycle, and sets sptr = (sptr+STRIDE) mod DEPTH.
  - count = sptr, zero-extended.
  - Write to the address currently being streamed is read-first.
  - full=0, empty=0, err=0.
- Pointer arithmetic is AW bits with natural wrap. count is AW+1 bits, so DEPTH is representable.

## Timing
- Read latency is 1 cycle in every mode: request in cycle N gives read_data/read_valid in cycle N+1.
- Back-to-back reads every cycle are supported; read_valid stays high continuously.
- read_data holds its last value when read_valid=0.
- Write / push is visible to a read issued on the following cycle, or later.
- full, empty and count reflect all pushes/pops accepted at the previous edge.
- Reset asserted mid-operation: at the next edge all outputs take reset values. An in-flight read is dropped, so read_valid=0 in the cycle after reset. Requests coincident with reset are ignored.

## Test plan
- RAM, DATA_WIDTH=32, DEPTH=16:
  - write 0xDEADBEEF @5; read @5 next cycle → read_data=0xDEADBEEF, read_valid 1 cycle later.
  - Same-cycle write 0x1 / read @5 → returns 0xDEADBEEF.
  - addr0=0x25 aliases address 5.
- FIFO, DEPTH=4:
  - push 1,2,3,4 → full=1, count=4; 5th push → rejected, err=1.
  - pop ×4 → 1,2,3,4 in order, then empty=1; 5th pop → read_valid stays 0.
- FIFO wrap, DEPTH=4:
  - push 10,11,12, pop 2, push 13,14,15 → count=4.
  - Push+pop while full → count stays 4, pop order 12,13,14,15.
  - Push+pop while empty → count=1, no read_valid.
- STREAM, DEPTH=8, STRIDE=3:
  - preload mem[i]=i.
  - 9 consecutive read_en → read_data 0,3,6,1,4,7,2,5,0; count follows 3,6,1,4,7,2,5,0,3; read_valid continuous.
- Reset mid-FIFO:
  - count=3 with a pop issued in the same cycle reset rises → next cycle count=0, empty=1, read_valid=0, err=0, read_data=0.
- Parameter sweep: DATA_WIDTH 8/16/32, DEPTH 2/4096 → random RAM/FIFO traffic matches a scoreboard model; a DEPTH=4096 FIFO reaches count=4096 with full=1.
